// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: 1 Hz / scan / blink enables, HH:MM:SS counters and a
// two-button time-set state machine, all in the single in_50MHz domain.
module clock_time_ctrl #(
    parameter int CLK_HZ       = 50000000,
    parameter int SCAN_HZ      = 1000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       in_50MHz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       tick_1hz,
    output logic       scan_en,
    output logic       blink
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PRESC_W  = $clog2(CLK_HZ + 1);
    localparam int SCAN_W   = $clog2(SCAN_DIV + 1);
    localparam int DEB_W    = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_HZ / 2 - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [PRESC_W-1:0] presc_reg;
    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic               tick_reg, scan_en_reg, blink_reg;
    logic [4:0]         hours_reg;
    logic [5:0]         minutes_reg, seconds_reg;

    logic sec_wrap, half_sec;
    logic advance, inc_hr, inc_min, exit_set;
    logic mode_press, inc_press;

    logic [1:0] raw_btn;
    logic [1:0] press;

    assign raw_btn = {btn_inc, btn_mode};

    // Per button: 2-flop synchroniser, then the accepted level only follows the
    // synced level after it has disagreed for DEBOUNCE_CYC consecutive cycles.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg, sync2_reg, level_reg, press_reg;
            logic [DEB_W-1:0] cnt_reg;

            always_ff @(posedge in_50MHz) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_btn[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                        press_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    assign mode_press = press[0];
    assign inc_press  = press[1];

    assign sec_wrap = (presc_reg == PRESC_LAST);
    assign half_sec = (presc_reg == PRESC_HALF);

    always_ff @(posedge in_50MHz) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A mode press always wins over a simultaneous inc press.
    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        inc_hr     = 1'b0;
        inc_min    = 1'b0;
        exit_set   = 1'b0;
        case (state_reg)
            ST_RUN: begin
                advance = sec_wrap;
                if (mode_press) state_next = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (mode_press)     state_next = ST_SET_MIN;
                else if (inc_press) inc_hr = 1'b1;
            end
            ST_SET_MIN: begin
                if (mode_press) begin
                    state_next = ST_RUN;
                    exit_set   = 1'b1;
                end else if (inc_press) begin
                    inc_min = 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Leaving set mode realigns the second boundary to the moment of exit.
    always_ff @(posedge in_50MHz) begin
        if (reset || exit_set) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
            blink_reg <= 1'b0;
        end else begin
            presc_reg <= sec_wrap ? '0 : presc_reg + 1'b1;
            tick_reg  <= sec_wrap;
            if (sec_wrap || half_sec) blink_reg <= ~blink_reg;
        end
    end

    always_ff @(posedge in_50MHz) begin
        if (reset) begin
            scan_cnt_reg <= '0;
            scan_en_reg  <= 1'b0;
        end else begin
            scan_cnt_reg <= (scan_cnt_reg == SCAN_LAST) ? '0 : scan_cnt_reg + 1'b1;
            scan_en_reg  <= (scan_cnt_reg == SCAN_LAST);
        end
    end

    always_ff @(posedge in_50MHz) begin
        if (reset) begin
            hours_reg   <= '0;
            minutes_reg <= '0;
            seconds_reg <= '0;
        end else if (advance) begin
            if (seconds_reg == 6'd59) begin
                seconds_reg <= '0;
                if (minutes_reg == 6'd59) begin
                    minutes_reg <= '0;
                    hours_reg   <= (hours_reg == 5'd23) ? 5'd0 : hours_reg + 5'd1;
                end else begin
                    minutes_reg <= minutes_reg + 6'd1;
                end
            end else begin
                seconds_reg <= seconds_reg + 6'd1;
            end
        end else if (inc_hr) begin
            hours_reg <= (hours_reg == 5'd23) ? 5'd0 : hours_reg + 5'd1;
        end else if (inc_min) begin
            minutes_reg <= (minutes_reg == 6'd59) ? 6'd0 : minutes_reg + 6'd1;
        end else if (exit_set) begin
            seconds_reg <= '0;
        end
    end

    assign hours    = hours_reg;
    assign minutes  = minutes_reg;
    assign seconds  = seconds_reg;
    assign mode     = state_reg;
    assign tick_1hz = tick_reg;
    assign scan_en  = scan_en_reg;
    assign blink    = blink_reg;

endmodule

// File: tb/tb_clock_time_ctrl.sv
module tb_clock_time_ctrl;

    localparam int CLK_HZ   = 20;
    localparam int SCAN_HZ  = 5;
    localparam int DEB      = 3;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [1:0] mode;
    logic       tick_1hz, scan_en, blink;

    always #5 clk = ~clk;

    clock_time_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .SCAN_HZ     (SCAN_HZ),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .in_50MHz(clk),
        .reset   (reset),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .mode    (mode),
        .tick_1hz(tick_1hz),
        .scan_en (scan_en),
        .blink   (blink)
    );

    typedef struct packed {
        logic [4:0] hrs;
        logic [5:0] mins;
        logic [5:0] secs;
        logic [1:0] md;
        logic       tick;
        logic       scan;
        logic       blk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int mh = 0, mm = 0, ms = 0, mmode = 0;
    int n = 0, sm = 0;
    bit acc[2];
    bit pend[2];
    bit hist[2][DEB+2];

    task automatic model_step(input bit r, input bit bm, input bit bi);
        exp_t e;
        bit   wrap, exit_set, flip;
        int   total;
        bit   raw[2];
        raw[0] = bm;
        raw[1] = bi;
        e = '0;
        if (r) begin
            mh = 0; mm = 0; ms = 0; mmode = 0; n = 0; sm = 0;
            for (int b = 0; b < 2; b++) begin
                acc[b]  = 1'b0;
                pend[b] = 1'b0;
                for (int i = 0; i < DEB + 2; i++) hist[b][i] = 1'b0;
            end
        end else begin
            exit_set = 1'b0;
            wrap = ((n + 1) % CLK_HZ) == 0;
            if (mmode == 0 && wrap) begin
                total = (mh * 3600 + mm * 60 + ms + 1) % 86400;
                mh = total / 3600;
                mm = (total / 60) % 60;
                ms = total % 60;
            end
            if (pend[0]) begin
                if (mmode == 2) begin
                    ms = 0;
                    exit_set = 1'b1;
                end
                mmode = (mmode + 1) % 3;
            end else if (pend[1]) begin
                if (mmode == 1)      mh = (mh + 1) % 24;
                else if (mmode == 2) mm = (mm + 1) % 60;
            end
            n  = exit_set ? 0 : n + 1;
            sm = sm + 1;
            for (int b = 0; b < 2; b++) begin
                for (int i = DEB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = raw[b];
                flip = 1'b1;
                for (int i = 2; i < DEB + 2; i++) if (hist[b][i] == acc[b]) flip = 1'b0;
                pend[b] = 1'b0;
                if (flip) begin
                    acc[b]  = !acc[b];
                    pend[b] = acc[b];
                end
            end
            e.tick = !exit_set && ((n % CLK_HZ) == 0);
            e.scan = (sm % SCAN_DIV) == 0;
            e.blk  = ((n / (CLK_HZ / 2)) % 2) == 1;
        end
        e.hrs  = 5'(mh);
        e.mins = 6'(mm);
        e.secs = 6'(ms);
        e.md   = 2'(mmode);
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(reset, btn_mode, btn_inc);
        end
    end

    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {hours, minutes, seconds, mode, tick_1hz, scan_en, blink};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %0d:%0d:%0d mode=%0d tick=%0b scan=%0b blink=%0b, expected %0d:%0d:%0d mode=%0d tick=%0b scan=%0b blink=%0b",
                             cyc, got.hrs, got.mins, got.secs, got.md, got.tick, got.scan, got.blk,
                             e.hrs, e.mins, e.secs, e.md, e.tick, e.scan, e.blk);
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if ({hours, minutes, seconds, mode, tick_1hz, scan_en, blink} !== '0) begin
            errors++;
            $display("FAIL reset state (%s): got %0d:%0d:%0d mode=%0d tick=%0b scan=%0b blink=%0b, expected all 0",
                     tag, hours, minutes, seconds, mode, tick_1hz, scan_en, blink);
        end else begin
            $display("PASS reset state (%s): all outputs 0", tag);
        end
    endtask

    task automatic wait_tick(input int limit);
        int k;
        bit seen;
        seen = 1'b0;
        for (k = 0; k < limit && !seen; k++) begin
            step(1);
            if (tick_1hz === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait for tick_1hz: none within %0d cycles", limit);
        end else begin
            $display("PASS tick_1hz seen after %0d cycles", k);
        end
    endtask

    task automatic press(input int which, input int hold);
        if (which == 0) btn_mode = 1'b1; else btn_inc = 1'b1;
        step(hold);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(8);
    endtask

    task automatic press_n(input int which, input int count);
        for (int i = 0; i < count; i++) press(which, 4);
    endtask

    initial begin
        int hold;
        reset = 1'b1;
        step(2);
        check_reset_state("power-on");
        reset = 1'b0;
        wait_tick(CLK_HZ + 2);
        step(20);

        press(0, 4);
        press_n(1, (23 - mh + 24) % 24);
        press(0, 4);
        press_n(1, (59 - mm + 60) % 60);
        press(0, 4);
        step(60 * CLK_HZ + 5);

        press(0, 6);
        press_n(1, 25);

        press(1, 2);
        press(1, 4);
        press(1, 100);

        press(0, 4);
        press_n(1, (59 - mm + 60) % 60);
        press(1, 4);
        press(0, 4);
        step(25);

        press(0, 4);
        press_n(1, (5 - mh + 24) % 24);
        press(0, 4);
        press_n(1, (17 - mm + 60) % 60);
        press(0, 4);
        step(7);
        press(0, 4);
        reset = 1'b1;
        step(1);
        check_reset_state("mid-set");
        reset = 1'b0;
        step(25);

        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            btn_mode = ($urandom_range(0, 3) == 0);
            btn_inc  = ($urandom_range(0, 1) == 0);
            hold     = $urandom_range(1, 8);
            step(hold);
        end
        reset    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(30);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
